// File: rtl/kuznechik_pkg.sv
// Shared definitions for the kuznechik core arbiter: block width, FSM states
// and the round-robin index helper.
package kuznechik_pkg;

    localparam int unsigned BLOCK_W  = 128;
    localparam int unsigned CORE_LAT = 163;
    localparam int unsigned WD_W     = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        ACK,
        GAP,
        RECOVER
    } arb_state_e;

    function automatic int unsigned rr_index(int unsigned base, int unsigned off, int unsigned n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/kuz_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_i, with wrap.
module kuz_rr_arbiter
    import kuznechik_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned IW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    last_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IW-1:0]    idx_o,
    output logic             any_o
);

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            if (!any_o && req_i[IW'(rr_index(32'(last_i), i, N_REQ))]) begin
                any_o = 1'b1;
                idx_o = IW'(rr_index(32'(last_i), i, N_REQ));
                gnt_o[IW'(rr_index(32'(last_i), i, N_REQ))] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/kuznechik_arbiter.sv
// Shares one kuznechik_cipher core between N_REQ requesters; each transaction is
// sequenced end to end, and a watchdog resets the core if it never answers.
module kuznechik_arbiter
    import kuznechik_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned RST_CYC = 2
) (
    input  logic                     clk_i,
    input  logic                     resetn_i,
    input  logic [N_REQ-1:0]         req_valid_i,
    input  logic [N_REQ*BLOCK_W-1:0] req_data_i,
    output logic [N_REQ-1:0]         req_ready_o,
    output logic [N_REQ-1:0]         resp_valid_o,
    output logic [BLOCK_W-1:0]       resp_data_o,
    output logic                     resp_err_o,
    input  logic [N_REQ-1:0]         resp_ready_i,
    output logic                     err_timeout_o,
    input  logic                     err_clr_i,
    output logic                     core_request_o,
    output logic                     core_ack_o,
    output logic [BLOCK_W-1:0]       core_data_o,
    input  logic                     core_busy_i,
    input  logic                     core_valid_i,
    input  logic [BLOCK_W-1:0]       core_data_i,
    output logic                     core_resetn_o
);

    localparam int unsigned     IW      = $clog2(N_REQ);
    localparam int unsigned     RW      = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [RW-1:0]   RC_LAST = RW'(RST_CYC - 1);

    arb_state_e         state_q, state_d;
    logic [IW-1:0]      last_q, last_d;
    logic [IW-1:0]      gidx_q, gidx_d;
    logic [BLOCK_W-1:0] blk_q, blk_d;
    logic [BLOCK_W-1:0] rdata_q, rdata_d;
    logic               rerr_q, rerr_d;
    logic               err_q, err_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [RW-1:0]      rc_q, rc_d;
    logic               crst_q, crst_d;

    logic [N_REQ-1:0]   arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;
    logic               accept;

    kuz_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req_i  (req_valid_i),
        .last_i (last_q),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx),
        .any_o  (arb_any)
    );

    // The busy input only gates new accepts; an in-flight transaction ignores it.
    assign accept = (state_q == IDLE) && !core_busy_i && arb_any;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gidx_d  = gidx_q;
        blk_d   = blk_q;
        rdata_d = rdata_q;
        rerr_d  = rerr_q;
        wd_d    = wd_q;
        rc_d    = rc_q;
        crst_d  = crst_q;
        err_d   = (err_q && !err_clr_i) || (state_q == RECOVER);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    gidx_d  = arb_idx;
                    last_d  = arb_idx;
                    blk_d   = req_data_i[32'(arb_idx)*BLOCK_W +: BLOCK_W];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                wd_d = wd_q + 1'b1;
                if (core_valid_i) begin
                    rdata_d = core_data_i;
                    rerr_d  = 1'b0;
                    state_d = RESP;
                end else if (wd_q == WD_LAST) begin
                    rc_d    = '0;
                    crst_d  = 1'b0;
                    state_d = RECOVER;
                end
            end
            RESP: begin
                if (resp_ready_i[gidx_q]) begin
                    state_d = rerr_q ? IDLE : ACK;
                end
            end
            ACK: state_d = GAP;
            GAP: state_d = IDLE;
            RECOVER: begin
                if (rc_q == RC_LAST) begin
                    crst_d  = 1'b1;
                    rerr_d  = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    rc_d = rc_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
            last_q  <= IW'(N_REQ - 1);
            gidx_q  <= '0;
            blk_q   <= '0;
            rdata_q <= '0;
            rerr_q  <= 1'b0;
            err_q   <= 1'b0;
            wd_q    <= '0;
            rc_q    <= '0;
            crst_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gidx_q  <= gidx_d;
            blk_q   <= blk_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
            rc_q    <= rc_d;
            crst_q  <= crst_d;
        end
    end

    always_comb begin
        resp_valid_o = '0;
        if (state_q == RESP) begin
            resp_valid_o[gidx_q] = 1'b1;
        end
    end

    assign req_ready_o    = accept ? arb_gnt : '0;
    assign resp_data_o    = rdata_q;
    assign resp_err_o     = rerr_q;
    assign err_timeout_o  = err_q;
    assign core_request_o = (state_q == ISSUE);
    assign core_ack_o     = (state_q == ACK);
    assign core_data_o    = blk_q;
    assign core_resetn_o  = crst_q;

endmodule

// File: tb/tb_kuznechik_arbiter.sv
// Randomized bench for kuznechik_arbiter: requester agents, a behavioural core
// and a transaction-timeline reference model predicting every output each cycle.
module tb_kuznechik_arbiter;
    import kuznechik_pkg::*;

    localparam int N  = 4;
    localparam int TO = 20;
    localparam int RC = 2;
    localparam logic [127:0] TV_PT = 128'h1122334455667700ffeeddccbbaa9988;
    localparam logic [127:0] TV_CT = 128'h7f679d90bebc24305a468d42b9d4edcd;

    logic               clk_i = 1'b0;
    logic               resetn_i = 1'b0;
    logic [N-1:0]       req_valid_i = '0;
    logic [N*128-1:0]   req_data_i = '0;
    logic [N-1:0]       req_ready_o;
    logic [N-1:0]       resp_valid_o;
    logic [127:0]       resp_data_o;
    logic               resp_err_o;
    logic [N-1:0]       resp_ready_i = '0;
    logic               err_timeout_o;
    logic               err_clr_i = 1'b0;
    logic               core_request_o;
    logic               core_ack_o;
    logic [127:0]       core_data_o;
    logic               core_busy_i = 1'b0;
    logic               core_valid_i = 1'b0;
    logic [127:0]       core_data_i = '0;
    logic               core_resetn_o;

    always #5 clk_i = ~clk_i;

    kuznechik_arbiter #(.N_REQ(N), .TIMEOUT(TO), .RST_CYC(RC)) dut (
        .clk_i          (clk_i),
        .resetn_i       (resetn_i),
        .req_valid_i    (req_valid_i),
        .req_data_i     (req_data_i),
        .req_ready_o    (req_ready_o),
        .resp_valid_o   (resp_valid_o),
        .resp_data_o    (resp_data_o),
        .resp_err_o     (resp_err_o),
        .resp_ready_i   (resp_ready_i),
        .err_timeout_o  (err_timeout_o),
        .err_clr_i      (err_clr_i),
        .core_request_o (core_request_o),
        .core_ack_o     (core_ack_o),
        .core_data_o    (core_data_o),
        .core_busy_i    (core_busy_i),
        .core_valid_i   (core_valid_i),
        .core_data_i    (core_data_i),
        .core_resetn_o  (core_resetn_o)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // requester agents and stimulus knobs
    logic [N-1:0] pend = '0;
    logic [127:0] blk [N];
    bit gen_on = 0, rand_lat = 0, rst_assert = 1, arst_now = 0, clr_force = 0, busy_force = 0;
    int gen_pct = 0, lat_next = 5, hold_len = 0, bf_pct = 0, clr_pct = 0;

    // reference model: one transaction timeline
    bit in_txn, m_to, m_err;
    int acc_c, resp_at, hs_c, m_g, m_last, m_lat;
    logic [127:0] m_blk;
    int grants[$];

    // behavioural core
    bit cm_busy, cm_valid;
    int cm_cnt;
    logic [127:0] cm_res;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [127:0] core_f(input logic [127:0] pt);
        if (pt == TV_PT) return TV_CT;
        return {pt[63:0], pt[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    function automatic int rr_pick(input int last, input logic [N-1:0] v);
        for (int i = 1; i <= N; i++) begin
            if (v[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    function automatic int pick_lat();
        int r = int'($urandom_range(0, 9));
        if (r == 0) return 0;
        if (r == 1) return TO + int'($urandom_range(1, 3));
        if (r == 2) return TO;
        return int'($urandom_range(1, TO - 1));
    endfunction

    task automatic model_reset();
        in_txn = 0; hs_c = -1; m_last = N - 1; m_err = 0;
        cm_busy = 0; cm_valid = 0; cm_cnt = 0;
    endtask

    task automatic step();
        logic [N-1:0] exp_rdy, exp_rv;
        int  pick;
        bit  rec, resp_on, req_c;
        @(negedge clk_i);
        resetn_i = !rst_assert;
        if (rand_lat) lat_next = pick_lat();
        for (int k = 0; k < N; k++) begin
            req_valid_i[k] = pend[k] && !rst_assert;
            req_data_i[k*128 +: 128] = blk[k];
        end
        core_valid_i = cm_valid;
        core_data_i  = cm_valid ? cm_res : {$urandom, $urandom, $urandom, $urandom};
        busy_force   = (bf_pct > 0) && (int'($urandom_range(0, 99)) < bf_pct);
        core_busy_i  = cm_busy || busy_force;
        resp_ready_i = N'($urandom);
        resp_on = in_txn && cyc >= resp_at && hs_c < 0;
        if (resp_on && cyc < resp_at + hold_len) resp_ready_i[m_g] = 1'b0;
        err_clr_i = clr_force || ((clr_pct > 0) && (int'($urandom_range(0, 99)) < clr_pct));
        #1;
        exp_rdy = '0;
        pick = -1;
        if (!in_txn && !busy_force && resetn_i) pick = rr_pick(m_last, req_valid_i);
        if (pick >= 0) exp_rdy[pick] = 1'b1;
        check_eq("req_ready", 128'(req_ready_o), 128'(exp_rdy));
        req_c = in_txn && cyc == acc_c + 1;
        check_eq("core_request", 128'(core_request_o), 128'(req_c));
        if (req_c) check_eq("core_data", core_data_o, m_blk);
        rec = in_txn && m_to && cyc >= acc_c + 2 + TO && cyc < acc_c + 2 + TO + RC;
        check_eq("core_resetn", 128'(core_resetn_o), 128'(!rec));
        check_eq("err_timeout", 128'(err_timeout_o), 128'(m_err));
        exp_rv = '0;
        if (resp_on) exp_rv[m_g] = 1'b1;
        check_eq("resp_valid", 128'(resp_valid_o), 128'(exp_rv));
        if (resp_on) begin
            check_eq("resp_data", resp_data_o, m_to ? 128'(0) : core_f(m_blk));
            check_eq("resp_err", 128'(resp_err_o), 128'(m_to));
        end
        check_eq("core_ack", 128'(core_ack_o), 128'(in_txn && !m_to && hs_c >= 0 && cyc == hs_c + 1));
        if (!resetn_i) begin
            model_reset();
        end else begin
            m_err = (m_err && !err_clr_i) || rec;
            if (resp_on && resp_ready_i[m_g]) hs_c = cyc;
            if (in_txn && hs_c >= 0 && cyc == hs_c + (m_to ? 0 : 2)) in_txn = 0;
            if (pick >= 0) begin
                in_txn = 1; acc_c = cyc; m_g = pick; m_last = pick; m_blk = blk[pick];
                m_lat = lat_next; m_to = (lat_next == 0) || (lat_next > TO);
                resp_at = cyc + 2 + (m_to ? TO + RC : m_lat);
                hs_c = -1; pend[pick] = 1'b0;
                grants.push_back(pick);
            end
            if (!core_resetn_o) begin
                cm_busy = 0; cm_valid = 0;
            end else if (core_ack_o && cm_valid) begin
                cm_busy = 0; cm_valid = 0;
            end else if (core_request_o && !cm_busy) begin
                cm_busy = 1; cm_cnt = m_lat; cm_valid = (m_lat == 1); cm_res = core_f(core_data_o);
            end else if (cm_busy && !cm_valid && cm_cnt > 1) begin
                cm_cnt--;
                if (cm_cnt == 1) cm_valid = 1;
            end
            for (int k = 0; k < N; k++) begin
                if (gen_on && !pend[k] && int'($urandom_range(0, 99)) < gen_pct) begin
                    pend[k] = 1'b1;
                    blk[k] = {$urandom, $urandom, $urandom, $urandom};
                end
            end
        end
        if (arst_now) begin
            #2;
            req_valid_i = '0;
            resetn_i = 1'b0;
            rst_assert = 1;
            #1;
            check_eq("arst_req_ready", 128'(req_ready_o), 128'(0));
            check_eq("arst_resp_valid", 128'(resp_valid_o), 128'(0));
            check_eq("arst_resp_data", resp_data_o, 128'(0));
            check_eq("arst_core_request", 128'(core_request_o), 128'(0));
            check_eq("arst_core_data", core_data_o, 128'(0));
            check_eq("arst_core_resetn", 128'(core_resetn_o), 128'(1));
            model_reset();
            arst_now = 0;
        end
        cyc++;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((in_txn || pend != '0) && n < budget) begin
            step();
            n++;
        end
        check_eq("drain_budget", 128'(in_txn || pend != '0), 128'(0));
    endtask

    task automatic wait_grants(input int cnt, input int budget);
        int n = 0;
        while (grants.size() < cnt && n < budget) begin
            step();
            n++;
        end
        check_eq("grant_budget", 128'(grants.size() >= cnt), 128'(1));
    endtask

    initial begin
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        for (int k = 0; k < N; k++) blk[k] = '0;
        model_reset();
        repeat (3) step();
        rst_assert = 0;
        repeat (2) step();

        // single request with the reference vector
        pend[0] = 1'b1; blk[0] = TV_PT; lat_next = 12;
        drain(200);
        repeat (3) step();

        // all requesters valid straight out of reset
        rst_assert = 1;
        repeat (2) step();
        for (int k = 0; k < N; k++) blk[k] = {$urandom, $urandom, $urandom, $urandom};
        pend = '1; gen_on = 1; gen_pct = 100; lat_next = 3;
        rst_assert = 0;
        grants.delete();
        wait_grants(5, 400);
        for (int i = 0; i < 5; i++) begin
            if (i < grants.size()) check_eq("rr_order", 128'(grants[i]), 128'(exp_seq[i]));
        end
        gen_on = 0;
        drain(400);

        // long response back-pressure while another requester waits
        blk[1] = {$urandom, $urandom, $urandom, $urandom};
        blk[2] = {$urandom, $urandom, $urandom, $urandom};
        pend = 4'b0110; lat_next = 6; hold_len = 50;
        drain(400);
        hold_len = 0;

        // hung core: recovery, sticky flag, then clear
        pend[3] = 1'b1; blk[3] = {$urandom, $urandom, $urandom, $urandom}; lat_next = 0;
        drain(200);
        repeat (10) step();
        check_eq("t4_err_sticky", 128'(err_timeout_o), 128'(1));
        clr_force = 1; step(); clr_force = 0;
        step();
        check_eq("t4_err_cleared", 128'(err_timeout_o), 128'(0));
        // clear held throughout a timeout: the set during recovery still lands
        clr_force = 1; pend[0] = 1'b1; lat_next = 0;
        drain(200);
        clr_force = 0;

        // core answer on the last watchdog cycle, then one cycle too late
        pend[1] = 1'b1; blk[1] = {$urandom, $urandom, $urandom, $urandom}; lat_next = TO;
        drain(200);
        pend[2] = 1'b1; blk[2] = {$urandom, $urandom, $urandom, $urandom}; lat_next = TO + 1;
        drain(200);

        // asynchronous reset in the middle of WAIT
        pend[2] = 1'b1; lat_next = 15;
        for (int n = 0; n < 50 && !(in_txn && cyc >= acc_c + 5); n++) step();
        check_eq("t6_in_wait", 128'(in_txn), 128'(1));
        arst_now = 1;
        step();
        for (int k = 0; k < N; k++) blk[k] = {$urandom, $urandom, $urandom, $urandom};
        pend = '1;
        repeat (2) step();
        rst_assert = 0;
        grants.delete();
        wait_grants(1, 20);
        if (grants.size() > 0) check_eq("t6_first_grant", 128'(grants[0]), 128'(0));
        drain(400);

        // randomized traffic
        gen_on = 1; gen_pct = 25; rand_lat = 1; bf_pct = 10; clr_pct = 5;
        repeat (1500) step();
        gen_on = 0;
        drain(2000);
        bf_pct = 0; clr_pct = 0; rand_lat = 0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got cycle %0d, expected completion", cyc);
        $fatal(1, "time limit");
    end

endmodule
